// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: enable-side controller for a gated clock domain.
// Runs on the free-running clock upstream of the gate cell. After IDLE_CYCLES
// consecutive idle cycles it drops clk_en_o. On activity it restores the clock,
// waits WAKE_CYCLES settling cycles, then acknowledges a 4-phase wake request.
// Optional gated-cycle statistics counter: define CLK_GATE_CTRL_STATS_EN.
// Without it gated_cycles_o is tied to 0 and stats_clr_i is ignored.
module clk_gate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 4,
  parameter int CNT_W = $clog2((IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES) + 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        busy_i,
  input  logic        sw_en_i,
  input  logic        test_en_i,
  input  logic        wake_req_i,
  output logic        wake_ack_o,
  output logic        clk_en_o,
  output logic        gated_o,
  input  logic        stats_clr_i,
  output logic [31:0] gated_cycles_o
);

  typedef enum logic [1:0] {
    ON   = 2'd0,
    IDLE = 2'd1,
    OFF  = 2'd2,
    WAKE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_en_q;
  logic             gated_q;
  logic             wake_ack_q;
  logic             act;

  // Any source of activity keeps (or brings) the domain clocked.
  assign act = busy_i | sw_en_i | wake_req_i;

  // State and shared down-counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ON;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state decode; WAKE always runs to completion regardless of act.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ON: begin
        if (!act) begin
          state_d = IDLE;
          cnt_d   = IDLE_LD;
        end
      end
      IDLE: begin
        if (act)                state_d = ON;
        else if (cnt_q == '0)   state_d = OFF;
        else                    cnt_d   = cnt_q - CNT_ONE;
      end
      OFF: begin
        if (act) begin
          state_d = WAKE;
          cnt_d   = WAKE_LD;
        end
      end
      WAKE: begin
        if (cnt_q == '0) state_d = ON;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      default: begin
        state_d = ON;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs decoded from the next state so they line up with it.
  // Reset forces the enable high at once so the domain sees its own reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_en_q   <= 1'b1;
      gated_q    <= 1'b0;
      wake_ack_q <= 1'b0;
    end else begin
      clk_en_q   <= (state_d != OFF);
      gated_q    <= (state_d == OFF);
      wake_ack_q <= (state_d == ON) & wake_req_i;
    end
  end

  // Test mode overrides the enable without touching the FSM.
  assign clk_en_o   = clk_en_q | test_en_i;
  assign gated_o    = gated_q;
  assign wake_ack_o = wake_ack_q;

`ifdef CLK_GATE_CTRL_STATS_EN
  logic [31:0] gated_cnt_q;

  // Saturating count of cycles spent in OFF; clear wins over increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                       gated_cnt_q <= '0;
    else if (stats_clr_i)                            gated_cnt_q <= '0;
    else if (state_q == OFF && gated_cnt_q != '1)    gated_cnt_q <= gated_cnt_q + 32'd1;
  end

  assign gated_cycles_o = gated_cnt_q;
`else
  logic unused_stats_clr;

  assign unused_stats_clr = stats_clr_i;
  assign gated_cycles_o   = '0;
`endif

endmodule
